// File: rtl/team_06_adc_capture_ctrl.sv
// Serial ADC capture controller: frames cs_n/sck, shifts in 8-bit samples MSB first, buffers them in a FIFO.
// Optional saturating drop counter output ovf_count when TEAM06_ADC_CAPTURE_OVF_CNT_EN is defined.
module team_06_adc_capture_ctrl #(
   parameter int unsigned DIV   = 4,
   parameter int unsigned GAP   = 4,
   parameter int unsigned DEPTH = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    en,
   input  logic                    adc_serial_in,
   output logic                    sck,
   output logic                    cs_n,
   output logic [7:0]              sample_data,
   output logic                    sample_valid,
   input  logic                    sample_ready,
   output logic [$clog2(DEPTH):0]  fifo_count,
   output logic                    overflow,
`ifdef TEAM06_ADC_CAPTURE_OVF_CNT_EN
   output logic [7:0]              ovf_count,
`endif
   input  logic                    clr_ovf,
   output logic                    busy
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   typedef enum logic [2:0] {ST_IDLE, ST_SETUP, ST_SHIFT, ST_PUSH, ST_GAP} state_e;

   state_e          state_q, state_d;
   logic [7:0]      cnt_q, cnt_d;
   logic [2:0]      bit_q, bit_d;
   logic            hi_q, hi_d;
   logic [7:0]      shift_q, shift_d;
   logic            sck_q, sck_d;
   logic            cs_n_q, cs_n_d;
   logic            busy_q, busy_d;
   logic [7:0]      mem_q [DEPTH];
   logic [7:0]      mem_d [DEPTH];
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic [7:0]      data_q, data_d;
   logic            valid_q, valid_d;
   logic            ovf_q, ovf_d;
   logic [7:0]      ovf_cnt_q, ovf_cnt_d;
   logic            push, pop, full, wr_en, drop;

   // Frame sequencing, bit timing and FIFO next-state
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      bit_d     = bit_q;
      hi_d      = hi_q;
      shift_d   = shift_q;
      mem_d     = mem_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      ovf_d     = ovf_q;
      ovf_cnt_d = ovf_cnt_q;
      push      = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (en) begin
               state_d = ST_SETUP;
               cnt_d   = 8'(DIV - 1);
            end
         end
         ST_SETUP: begin
            if (cnt_q == 8'd0) begin
               state_d = ST_SHIFT;
               cnt_d   = 8'(DIV - 1);
               hi_d    = 1'b0;
               bit_d   = 3'd0;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         ST_SHIFT: begin
            if (cnt_q != 8'd0) begin
               cnt_d = cnt_q - 8'd1;
            end else if (!hi_q) begin
               // sck rising: capture the data bit on this edge
               hi_d    = 1'b1;
               cnt_d   = 8'(DIV - 1);
               shift_d = {shift_q[6:0], adc_serial_in};
            end else if (bit_q == 3'd7) begin
               hi_d    = 1'b0;
               state_d = ST_PUSH;
            end else begin
               hi_d  = 1'b0;
               bit_d = bit_q + 3'd1;
               cnt_d = 8'(DIV - 1);
            end
         end
         ST_PUSH: begin
            push    = 1'b1;
            state_d = ST_GAP;
            cnt_d   = 8'(GAP - 1);
         end
         ST_GAP: begin
            if (cnt_q == 8'd0) begin
               state_d = en ? ST_SETUP : ST_IDLE;
               cnt_d   = 8'(DIV - 1);
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      sck_d  = (state_d == ST_SHIFT) && hi_d;
      cs_n_d = (state_d == ST_IDLE) || (state_d == ST_GAP);
      busy_d = (state_d != ST_IDLE);

      // A pop in the same cycle frees the slot, so a full FIFO still accepts the push
      full  = (count_q == CW'(DEPTH));
      pop   = valid_q && sample_ready;
      wr_en = push && (!full || pop);
      drop  = push && full && !pop;

      if (wr_en) begin
         mem_d[wr_ptr_q] = shift_q;
         wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      count_d = count_q + CW'(wr_en) - CW'(pop);
      valid_d = (count_d != CW'(0));
      data_d  = valid_d ? mem_d[rd_ptr_d] : 8'h00;

      if (drop) begin
         ovf_d     = 1'b1;
         ovf_cnt_d = clr_ovf ? 8'd1 : ((ovf_cnt_q == 8'hFF) ? ovf_cnt_q : ovf_cnt_q + 8'd1);
      end else if (clr_ovf) begin
         ovf_d     = 1'b0;
         ovf_cnt_d = 8'd0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         cnt_q     <= 8'd0;
         bit_q     <= 3'd0;
         hi_q      <= 1'b0;
         shift_q   <= 8'd0;
         sck_q     <= 1'b0;
         cs_n_q    <= 1'b1;
         busy_q    <= 1'b0;
         mem_q     <= '{default: 8'h00};
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         data_q    <= 8'h00;
         valid_q   <= 1'b0;
         ovf_q     <= 1'b0;
         ovf_cnt_q <= 8'd0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bit_q     <= bit_d;
         hi_q      <= hi_d;
         shift_q   <= shift_d;
         sck_q     <= sck_d;
         cs_n_q    <= cs_n_d;
         busy_q    <= busy_d;
         mem_q     <= mem_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
         ovf_q     <= ovf_d;
         ovf_cnt_q <= ovf_cnt_d;
      end
   end

   assign sck          = sck_q;
   assign cs_n         = cs_n_q;
   assign busy         = busy_q;
   assign sample_data  = data_q;
   assign sample_valid = valid_q;
   assign fifo_count   = count_q;
   assign overflow     = ovf_q;
`ifdef TEAM06_ADC_CAPTURE_OVF_CNT_EN
   assign ovf_count    = ovf_cnt_q;
`else
   logic unused_ovf_cnt;
   assign unused_ovf_cnt = ^ovf_cnt_q;
`endif

endmodule

// File: tb/tb_team_06_adc_capture_ctrl.sv
// Scoreboard bench for team_06_adc_capture_ctrl (DIV=4, GAP=4, DEPTH=4) with a behavioural ADC model.
module tb_team_06_adc_capture_ctrl;

   logic       clk, rst, en, adc_serial_in, sample_ready, clr_ovf;
   logic       sck, cs_n, sample_valid, overflow, busy;
   logic [7:0] sample_data;
   logic [2:0] fifo_count;
`ifdef TEAM06_ADC_CAPTURE_OVF_CNT_EN
   logic [7:0] ovf_count;
`endif

   team_06_adc_capture_ctrl #(.DIV(4), .GAP(4), .DEPTH(4)) dut (
      .clk(clk), .rst(rst), .en(en), .adc_serial_in(adc_serial_in),
      .sck(sck), .cs_n(cs_n), .sample_data(sample_data), .sample_valid(sample_valid),
      .sample_ready(sample_ready), .fifo_count(fifo_count), .overflow(overflow),
`ifdef TEAM06_ADC_CAPTURE_OVF_CNT_EN
      .ovf_count(ovf_count),
`endif
      .clr_ovf(clr_ovf), .busy(busy)
   );

   int n_cmp = 0;
   int n_err = 0;
   logic [7:0] exp_q[$];
   logic [7:0] adc_q[$];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout required finish");
      $fatal(1);
   end

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // ADC model: new byte per cs_n fall, next bit presented after each sck rise
   logic [7:0] cur = 8'h00;
   int         bitidx = 0;
   logic       prev_sck = 1'b0, prev_cs = 1'b1;
   always @(negedge clk) begin
      if (cs_n) begin
         bitidx = 0;
      end else if (prev_cs) begin
         cur    = (adc_q.size() > 0) ? adc_q.pop_front() : 8'h00;
         bitidx = 0;
      end else if (sck && !prev_sck) begin
         bitidx++;
      end
      adc_serial_in = (bitidx < 8) ? cur[3'(7 - bitidx)] : 1'b0;
      prev_sck = sck;
      prev_cs  = cs_n;
   end

   // Monitor: compare every accepted head sample against the scoreboard
   always @(negedge clk) begin
      if (!rst && sample_valid && sample_ready) begin
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL pop_unexpected: got 0x%0h required no sample", sample_data);
         end else begin
            logic [7:0] e;
            e = exp_q.pop_front();
            if (sample_data != e) begin
               n_err++;
               $display("FAIL pop_data: got 0x%0h required 0x%0h", sample_data, e);
            end
         end
      end
   end

   initial begin
      int   rises, valid_cyc, cs69, cs70, cnt, lows;
      logic p;
      rst = 1'b1; en = 1'b0; sample_ready = 1'b0; clr_ovf = 1'b0;
      step(3);
      check("rst_sck", sck, 0);
      check("rst_cs_n", cs_n, 1);
      check("rst_data", sample_data, 0);
      check("rst_valid", sample_valid, 0);
      check("rst_count", fifo_count, 0);
      check("rst_ovf", overflow, 0);
      check("rst_busy", busy, 0);
      rst = 1'b0;
      step(2);

      // Single frame of 0xA5: timing of valid and cs_n
      adc_q.push_back(8'hA5);
      en = 1'b1;
      step(1);
      en = 1'b0;
      rises = 0; valid_cyc = -1; cs69 = -1; cs70 = -1; p = sck;
      for (int cyc = 1; cyc <= 90; cyc++) begin
         if (sck && !p) rises++;
         if (cyc == 69) cs69 = int'(cs_n);
         if (cyc == 70) cs70 = int'(cs_n);
         if (sample_valid && valid_cyc < 0) valid_cyc = cyc;
         p = sck;
         step(1);
      end
      check("f1_valid_cycle", valid_cyc, 70);
      check("f1_sck_rises", rises, 8);
      check("f1_cs_n_push", cs69, 0);
      check("f1_cs_n_after", cs70, 1);
      check("f1_count", fifo_count, 1);
      check("f1_busy", busy, 0);
      exp_q.push_back(8'hA5);
      sample_ready = 1'b1;
      step(1);
      sample_ready = 1'b0;
      check("f1_drained", fifo_count, 0);

      // Continuous capture with no consumer: 2 drops
      for (int b = 1; b <= 6; b++) adc_q.push_back(8'(b));
      en = 1'b1;
      cnt = 0; p = cs_n;
      for (int cyc = 0; cyc < 800 && cnt < 6; cyc++) begin
         step(1);
         if (cs_n && !p) cnt++;
         p = cs_n;
      end
      en = 1'b0;
      check("full_frames", cnt, 6);
      step(8);
      check("full_busy", busy, 0);
      check("full_count", fifo_count, 4);
      check("full_head", sample_data, 8'h01);
      check("full_ovf", overflow, 1);
`ifdef TEAM06_ADC_CAPTURE_OVF_CNT_EN
      check("full_ovf_cnt", ovf_count, 2);
`endif
      clr_ovf = 1'b1;
      step(1);
      clr_ovf = 1'b0;
      check("clr_ovf", overflow, 0);
`ifdef TEAM06_ADC_CAPTURE_OVF_CNT_EN
      check("clr_ovf_cnt", ovf_count, 0);
`endif

      // Drop coinciding with clr_ovf keeps overflow set
      adc_q.push_back(8'h88);
      en = 1'b1;
      step(1);
      en = 1'b0;
      step(68);
      check("drop_push_cs_n", cs_n, 0);
      clr_ovf = 1'b1;
      step(1);
      clr_ovf = 1'b0;
      check("drop_clr_ovf", overflow, 1);
`ifdef TEAM06_ADC_CAPTURE_OVF_CNT_EN
      check("drop_clr_cnt", ovf_count, 1);
`endif
      clr_ovf = 1'b1;
      step(1);
      clr_ovf = 1'b0;
      check("clr_alone", overflow, 0);
      check("drop_count", fifo_count, 4);
      step(6);

      // Full FIFO with pop on the push cycle
      adc_q.push_back(8'h77);
      en = 1'b1;
      step(1);
      en = 1'b0;
      step(68);
      exp_q.push_back(8'h01);
      sample_ready = 1'b1;
      step(1);
      sample_ready = 1'b0;
      check("pp_count", fifo_count, 4);
      check("pp_ovf", overflow, 0);
      check("pp_head", sample_data, 8'h02);
      exp_q.push_back(8'h02); exp_q.push_back(8'h03);
      exp_q.push_back(8'h04); exp_q.push_back(8'h77);
      sample_ready = 1'b1;
      step(4);
      sample_ready = 1'b0;
      check("pp_drained", fifo_count, 0);
      check("pp_valid", sample_valid, 0);
      step(6);

      // Reset during the 5th sck high phase
      adc_q.push_back(8'hFF);
      en = 1'b1;
      step(1);
      en = 1'b0;
      rises = 0; p = sck;
      for (int cyc = 0; cyc < 200 && rises < 5; cyc++) begin
         if (sck && !p) rises++;
         p = sck;
         if (rises < 5) step(1);
      end
      check("rst5_rises", rises, 5);
      rst = 1'b1;
      step(1);
      check("rst5_sck", sck, 0);
      check("rst5_cs_n", cs_n, 1);
      check("rst5_count", fifo_count, 0);
      rst = 1'b0;
      step(2);
      check("rst5_idle", busy, 0);
      adc_q.push_back(8'h3C);
      en = 1'b1;
      step(1);
      en = 1'b0;
      cnt = 0;
      while (!sample_valid && cnt < 150) begin
         step(1);
         cnt++;
      end
      check("rst5_valid", sample_valid, 1);
      exp_q.push_back(8'h3C);
      sample_ready = 1'b1;
      step(1);
      sample_ready = 1'b0;
      check("rst5_drained", fifo_count, 0);
      step(6);

      // en dropped mid-SHIFT: frame completes, then idle
      adc_q.push_back(8'h5A);
      adc_q.push_back(8'h99);
      en = 1'b1;
      rises = 0; p = sck;
      for (int cyc = 0; cyc < 200 && rises < 3; cyc++) begin
         step(1);
         if (sck && !p) rises++;
         p = sck;
      end
      en = 1'b0;
      cnt = 0;
      while (!sample_valid && cnt < 150) begin
         step(1);
         cnt++;
      end
      check("endrop_valid", sample_valid, 1);
      check("endrop_count", fifo_count, 1);
      cnt = 0;
      while (busy && cnt < 20) begin
         step(1);
         cnt++;
      end
      check("endrop_busy", busy, 0);
      lows = 0;
      for (int cyc = 0; cyc < 100; cyc++) begin
         if (!cs_n) lows++;
         step(1);
      end
      check("endrop_no_cs", lows, 0);
      exp_q.push_back(8'h5A);
      sample_ready = 1'b1;
      step(1);
      sample_ready = 1'b0;
      check("scoreboard_empty", exp_q.size(), 0);
      step(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
